mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles mem_req_valid is held before the transaction is aborted (legal range 2..255).
REQ-002 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid, input, 1 (N=0,1), meaning requester N has a memory transaction pending.
REQ-005 SHALL have ports reqN_rw, input, 1, meaning 0=read, 1=write.
REQ-006 SHALL have ports reqN_addr, input, 32, the transaction address.
REQ-007 SHALL have ports reqN_dataout, input, 128, the write data from requester N.
REQ-008 SHALL have ports reqN_datain, output, 128, the read data returned to requester N.
REQ-009 SHALL have ports reqN_ready, output, 1, a one-cycle completion pulse to requester N.
REQ-010 SHALL have ports reqN_err, output, 1, asserted with reqN_ready when the transaction timed out.
REQ-011 SHALL have mem_req_addr output 32, mem_req_dataout output 128, mem_req_rw output 1 and mem_req_valid output 1, forming the shared memory request.
REQ-012 SHALL have mem_req_datain input 128 and mem_req_ready input 1, forming the memory response.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-014 SHALL arbitrate in IDLE when any reqN_valid=1:
- the winner is latched together with its addr, rw and dataout;
- the FSM moves to BUSY on the next edge.
REQ-015 SHALL use round-robin arbitration: when both requesters are valid, the requester not served last wins; a lone valid requester always wins.
REQ-016 SHALL drive mem_req_valid=1 and the latched addr/rw/dataout on mem_req_* only in BUSY, holding them stable throughout BUSY.
REQ-017 SHALL complete a transaction in BUSY on a cycle where mem_req_ready=1:
- for a read, mem_req_datain is captured into the winner's reqN_datain register;
- the FSM moves to RESP.
REQ-018 SHALL count BUSY cycles in an 8-bit counter cleared on entry to BUSY.
REQ-019 SHALL abort when the counter reaches TIMEOUT-1 with mem_req_ready=0: set the error flag, leave reqN_datain unchanged and move to RESP.
REQ-020 SHALL treat mem_req_ready=1 on the timeout cycle as a normal completion (ready has priority over timeout).
REQ-021 SHALL, in RESP, for exactly one cycle:
- assert the winner's reqN_ready, and reqN_err if the transaction aborted;
- record the winner as last served;
- then go to IDLE.
REQ-022 SHALL ignore reqN_valid in BUSY and RESP; a requester holds its request stable until its reqN_ready pulse.
REQ-023 SHALL have these latencies:
- request to mem_req_valid is 1 cycle;
- mem_req_ready to reqN_ready is 1 cycle;
- back-to-back transactions have a minimum 3-cycle turnaround (IDLE, BUSY, RESP).
REQ-024 SHALL hold reqN_datain until the next successful read for requester N; writes never modify reqN_datain.
REQ-025 SHALL never assert both reqN_ready outputs, or both reqN_err outputs, in the same cycle.

Reset
REQ-026 SHALL, on reset=1 at a rising edge:
- set the state to IDLE and clear the counter and error flag;
- set last-served to requester 1, so requester 0 wins the first tie;
- drive mem_req_valid, mem_req_rw, reqN_ready and reqN_err to 0;
- clear mem_req_addr, mem_req_dataout and reqN_datain to 0.
REQ-027 SHALL abandon an in-flight transaction when reset is asserted mid-transaction: mem_req_valid is 0 on the cycle after the reset edge and no reqN_ready pulse is issued.

Verification
REQ-028 SHALL be verified for a single read: req0 read of 0xAB00, memory ready after 2 BUSY cycles with data 0x3344 -> mem_req_valid high 2 cycles with addr 0xAB00 and rw=0, then req0_ready=1 for one cycle with req0_datain=0x3344.
REQ-029 SHALL be verified for a tie after reset: req0 write 0xBC00/0x1172 and req1 read 0xCD00 both asserted in the same cycle -> req0 served first; req1 served next, with mem_req_addr=0xCD00 after a 3-cycle turnaround.
REQ-030 SHALL be verified for round-robin: both requesters held continuously valid for 4 transactions -> grant order 0,1,0,1 and no simultaneous ready pulses.
REQ-031 SHALL be verified for timeout: TIMEOUT=8 with mem_req_ready held 0 -> mem_req_valid high exactly 8 cycles, then the winner gets reqN_ready=1 and reqN_err=1 with reqN_datain unchanged.
REQ-032 SHALL be verified for ready on the timeout cycle: mem_req_ready=1 on BUSY cycle 8 with TIMEOUT=8 and data 0x5566 -> normal completion with err=0 and datain=0x5566.
REQ-033 SHALL be verified for reset mid-operation: reset asserted on the second BUSY cycle -> mem_req_valid=0 the next cycle, no ready pulse, and the next tie is won by req0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// One transaction at a time: IDLE (grant) -> BUSY (memory handshake or timeout) -> RESP (completion pulse).
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic         req0_rw,
  input  logic [31:0]  req0_addr,
  input  logic [127:0] req0_dataout,
  output logic [127:0] req0_datain,
  output logic         req0_ready,
  output logic         req0_err,
  input  logic         req1_valid,
  input  logic         req1_rw,
  input  logic [31:0]  req1_addr,
  input  logic [127:0] req1_dataout,
  output logic [127:0] req1_datain,
  output logic         req1_ready,
  output logic         req1_err,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_dataout,
  output logic         mem_req_rw,
  output logic         mem_req_valid,
  input  logic [127:0] mem_req_datain,
  input  logic         mem_req_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state, state_nxt;
  logic         any_valid, grant, timeout_hit;
  logic         winner, last_served, err_flag;
  logic [7:0]   busy_cnt;
  logic [31:0]  lat_addr;
  logic         lat_rw;
  logic [127:0] lat_data;

  assign any_valid   = req0_valid | req1_valid;
  // A tie goes to whoever was not served last; a lone requester always wins.
  assign grant       = (req0_valid & req1_valid) ? ~last_served : req1_valid;
  assign timeout_hit = (busy_cnt == CNT_LAST) & ~mem_req_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = BUSY;
      BUSY:    if (mem_req_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    mem_req_valid   = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = '0;
    mem_req_dataout = '0;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    req0_err        = 1'b0;
    req1_err        = 1'b0;
    unique case (state)
      BUSY: begin
        mem_req_valid   = 1'b1;
        mem_req_rw      = lat_rw;
        mem_req_addr    = lat_addr;
        mem_req_dataout = lat_data;
      end
      RESP: begin
        req0_ready = ~winner;
        req1_ready = winner;
        req0_err   = ~winner & err_flag;
        req1_err   = winner & err_flag;
      end
      default: ;
    endcase
  end

  // NOTE: the wide datapath registers are reset too, because their zero value is architecturally visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt    <= '0;
      err_flag    <= 1'b0;
      last_served <= 1'b1;
      winner      <= 1'b0;
      lat_addr    <= '0;
      lat_rw      <= 1'b0;
      lat_data    <= '0;
      req0_datain <= '0;
      req1_datain <= '0;
    end else begin
      unique case (state)
        IDLE: if (any_valid) begin
          winner   <= grant;
          lat_addr <= grant ? req1_addr    : req0_addr;
          lat_rw   <= grant ? req1_rw      : req0_rw;
          lat_data <= grant ? req1_dataout : req0_dataout;
          busy_cnt <= '0;
          err_flag <= 1'b0;
        end
        BUSY: begin
          busy_cnt <= busy_cnt + 8'd1;
          // Ready wins over a coincident timeout; an abort leaves read data untouched.
          if (mem_req_ready) begin
            if (!lat_rw) begin
              if (winner) req1_datain <= mem_req_datain;
              else        req0_datain <= mem_req_datain;
            end
          end else if (timeout_hit) begin
            err_flag <= 1'b1;
          end
        end
        RESP:    last_served <= winner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction table run through a scoreboard, plus
// hand-written reset-in-flight and continuous round-robin sequences.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req0_rw, req1_valid, req1_rw;
  logic [31:0]  req0_addr, req1_addr;
  logic [127:0] req0_dataout, req1_dataout;
  logic [127:0] req0_datain, req1_datain;
  logic         req0_ready, req0_err, req1_ready, req1_err;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_dataout, mem_req_datain;
  logic         mem_req_rw, mem_req_valid, mem_req_ready;

  always #5 clock = ~clock;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_dataout(req0_dataout), .req0_datain(req0_datain),
    .req0_ready(req0_ready), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_dataout(req1_dataout), .req1_datain(req1_datain),
    .req1_ready(req1_ready), .req1_err(req1_err),
    .mem_req_addr(mem_req_addr), .mem_req_dataout(mem_req_dataout),
    .mem_req_rw(mem_req_rw), .mem_req_valid(mem_req_valid),
    .mem_req_datain(mem_req_datain), .mem_req_ready(mem_req_ready)
  );

  // lat_a/lat_b: BUSY cycle on which memory answers for the first/second
  // transaction of the vector (0 = never); rd_a/rd_b: the read data it returns.
  typedef struct {
    logic         v0, v1, rw0, rw1;
    logic [31:0]  addr0, addr1;
    logic [127:0] wd0, wd1;
    int           lat_a, lat_b;
    logic [127:0] rd_a, rd_b;
    logic         first;
  } vec_t;

  typedef struct {
    logic         id;
    logic [31:0]  addr;
    logic         rw;
    logic [127:0] wdata;
    int           busy;
    logic         err;
    logic [127:0] datain;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] shadow [2];
  vec_t         vt [8];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    shadow[0] = '0;
    shadow[1] = '0;
  endtask

  task automatic push_exp(input logic id, input vec_t v, input int k);
    exp_t e;
    int lat;
    logic [127:0] rd;
    lat      = (k == 0) ? v.lat_a : v.lat_b;
    rd       = (k == 0) ? v.rd_a  : v.rd_b;
    e.id     = id;
    e.addr   = id ? v.addr1 : v.addr0;
    e.rw     = id ? v.rw1   : v.rw0;
    e.wdata  = id ? v.wd1   : v.wd0;
    e.err    = (lat < 1) || (lat > TO);
    e.busy   = e.err ? TO : lat;
    if (!e.rw && !e.err) shadow[id] = rd;
    e.datain = shadow[id];
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n, served, busy, start_exp, lat;
    logic [127:0] rd;
    logic id;
    exp_t e;
    n = (v.v0 && v.v1) ? 2 : 1;
    if (n == 2) begin
      push_exp(v.first, v, 0);
      push_exp(~v.first, v, 1);
    end else begin
      push_exp(v.v1, v, 0);
    end
    req0_valid = v.v0; req0_rw = v.rw0; req0_addr = v.addr0; req0_dataout = v.wd0;
    req1_valid = v.v1; req1_rw = v.rw1; req1_addr = v.addr1; req1_dataout = v.wd1;
    served = 0; busy = 0; start_exp = 0;
    for (int cyc = 0; cyc < 100 && served < n; cyc++) begin
      @(negedge clock);
      lat = (served == 0) ? v.lat_a : v.lat_b;
      rd  = (served == 0) ? v.rd_a  : v.rd_b;
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (busy == 0) check($sformatf("%s start_cycle", tag), cyc, start_exp);
        if (sb.size() > 0) begin
          e = sb[0];
          check($sformatf("%s mem_addr", tag), mem_req_addr, e.addr);
          check($sformatf("%s mem_rw", tag), mem_req_rw, e.rw);
          check($sformatf("%s mem_dataout", tag), mem_req_dataout, e.wdata);
        end
        busy++;
        mem_req_ready  = (busy == lat);
        mem_req_datain = mem_req_ready ? rd : ~rd;
      end
      if (req0_ready || req1_ready) begin
        check($sformatf("%s single_ready", tag), req0_ready & req1_ready, 1'b0);
        check($sformatf("%s single_err", tag), req0_err & req1_err, 1'b0);
        check($sformatf("%s expected_ready", tag), sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e  = sb.pop_front();
          id = req1_ready;
          check($sformatf("%s grant", tag), id, e.id);
          check($sformatf("%s err", tag), id ? req1_err : req0_err, e.err);
          check($sformatf("%s datain", tag), id ? req1_datain : req0_datain, e.datain);
          check($sformatf("%s busy_cycles", tag), busy, e.busy);
          if (id) req1_valid = 1'b0;
          else    req0_valid = 1'b0;
        end
        busy = 0;
        served++;
        start_exp = cyc + 2;
      end
    end
    check($sformatf("%s served", tag), served, n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    check($sformatf("%s quiet", tag), {req0_ready, req1_ready, mem_req_valid}, 3'b000);
  endtask

  task automatic midop_reset();
    int seen = 0;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 32'h9000;
    mem_req_ready = 1'b0;
    for (int cyc = 0; cyc < 20 && seen < 2; cyc++) begin
      @(negedge clock);
      if (mem_req_valid) seen++;
      if (seen == 2) reset = 1'b1;
    end
    check("midop second_busy_seen", seen, 2);
    @(negedge clock);
    check("midop valid_after_reset", mem_req_valid, 1'b0);
    check("midop ready_after_reset", {req0_ready, req1_ready}, 2'b00);
    check("midop datain0_cleared", req0_datain, 128'h0);
    reset = 1'b0;
    req1_valid = 1'b0;
    shadow[0] = '0;
    shadow[1] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("midop no_pulse", {req0_ready, req1_ready, mem_req_valid}, 3'b000);
    end
  endtask

  task automatic rr_test();
    int ord [4] = '{0, 1, 0, 1};
    int got = 0;
    do_reset();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 32'h10;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 32'h20;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clock);
      mem_req_ready  = mem_req_valid;
      mem_req_datain = 128'h55;
      if (req0_ready || req1_ready) begin
        check("rr single_ready", req0_ready & req1_ready, 1'b0);
        check($sformatf("rr grant%0d", got), req1_ready, ord[got]);
        got++;
      end
    end
    check("rr transactions", got, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_dataout = '0;
    req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_dataout = '0;
    mem_req_ready = 1'b0; mem_req_datain = '0;

    vt[0] = '{v0:1, v1:1, rw0:1, rw1:0, addr0:32'hBC00, addr1:32'hCD00, wd0:128'h1172, wd1:128'h0,
              lat_a:2, lat_b:3, rd_a:128'h0, rd_b:128'h7788, first:0};
    vt[1] = '{v0:1, v1:0, rw0:0, rw1:0, addr0:32'hAB00, addr1:32'h0, wd0:128'h0, wd1:128'h0,
              lat_a:2, lat_b:0, rd_a:128'h3344, rd_b:128'h0, first:0};
    vt[2] = '{v0:1, v1:1, rw0:0, rw1:1, addr0:32'h2000, addr1:32'h3000, wd0:128'h0, wd1:128'hBEEF,
              lat_a:1, lat_b:4, rd_a:128'h0, rd_b:128'h9999, first:1};
    vt[3] = '{v0:1, v1:0, rw0:0, rw1:0, addr0:32'h4000, addr1:32'h0, wd0:128'h0, wd1:128'h0,
              lat_a:0, lat_b:0, rd_a:128'h0, rd_b:128'h0, first:0};
    vt[4] = '{v0:1, v1:1, rw0:0, rw1:1, addr0:32'h8000, addr1:32'h8100, wd0:128'h0, wd1:128'hF00D,
              lat_a:1, lat_b:2, rd_a:128'h1111, rd_b:128'h0, first:0};
    vt[5] = '{v0:0, v1:1, rw0:0, rw1:0, addr0:32'h0, addr1:32'h5000, wd0:128'h0, wd1:128'h0,
              lat_a:TO, lat_b:0, rd_a:128'h5566, rd_b:128'h0, first:1};
    vt[6] = '{v0:0, v1:1, rw0:0, rw1:1, addr0:32'h0, addr1:32'h6000, wd0:128'h0, wd1:128'h1234,
              lat_a:1, lat_b:0, rd_a:128'h0, rd_b:128'h0, first:1};
    vt[7] = '{v0:1, v1:1, rw0:0, rw1:0, addr0:32'h7000, addr1:32'h7100, wd0:128'h0, wd1:128'h0,
              lat_a:0, lat_b:7, rd_a:128'h0, rd_b:128'hAAAA, first:0};

    do_reset();
    check("reset mem_valid", mem_req_valid, 1'b0);
    check("reset mem_rw", mem_req_rw, 1'b0);
    check("reset mem_addr", mem_req_addr, 32'h0);
    check("reset mem_dataout", mem_req_dataout, 128'h0);
    check("reset ready_err", {req0_ready, req1_ready, req0_err, req1_err}, 4'h0);
    check("reset datain0", req0_datain, 128'h0);
    check("reset datain1", req1_datain, 128'h0);

    for (int i = 0; i < 8; i++) begin
      if (i == 4) midop_reset();
      run_vec(vt[i], $sformatf("vec%0d", i));
    end

    rr_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
